sp_div_udiv_26ns_14ns_12_seq: RTL and testbench



---
 rtl/sp_div_udiv_26ns_14ns_12_seq.sv | 178 +++++++++++++++++
 tb/tb_sp_div_udiv_26ns_14ns_12_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_div_udiv_26ns_14ns_12_seq.sv
// Sequential unsigned divider, 26-bit dividend / 14-bit divisor -> 12-bit quotient, one bit per clock.
// Optional macro SP_DIV_REM_OUT_EN: when defined, rem carries the remainder; otherwise rem is tied to 0.
module sp_div_udiv_26ns_14ns_12_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd26,
  parameter int unsigned din1_WIDTH = 32'd14,
  parameter int unsigned dout_WIDTH = 32'd12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd11;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic [13:0] div_reg;
  logic [13:0] prem_reg;
  logic [11:0] quo_reg;

  logic [11:0] dout_reg;
  logic        ovf_reg;

  logic        ovf_cond;
  logic        step_en;
  logic        load_res;
  logic        load_ovf;

  logic [13:0] step_prem_in;
  logic [11:0] step_quo_in;
  logic [13:0] step_div_in;
  logic [14:0] step_trial;
  logic [13:0] step_diff;
  logic        step_qbit;
  logic [13:0] step_prem;
  logic [11:0] step_quo;

  // The high dividend half must be below the divisor for the quotient to fit; also catches din1 == 0.
  assign ovf_cond = (din0[25:12] >= din1);

  // One restoring step. The first step runs on the transfer edge straight from the operand inputs,
  // so the twelve steps end on the eleventh edge after the transfer.
  always_comb begin
    if (state_reg == IDLE) begin
      step_prem_in = din0[25:12];
      step_quo_in  = din0[11:0];
      step_div_in  = din1;
    end else begin
      step_prem_in = prem_reg;
      step_quo_in  = quo_reg;
      step_div_in  = div_reg;
    end
    step_trial = {step_prem_in, step_quo_in[11]};
    step_qbit  = (step_trial >= {1'b0, step_div_in});
    // The true difference is below the divisor, so 14-bit wraparound arithmetic is exact.
    step_diff  = step_trial[13:0] - step_div_in;
    step_prem  = step_qbit ? step_diff : step_trial[13:0];
    step_quo   = {step_quo_in[10:0], step_qbit};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_en    = 1'b0;
    load_res   = 1'b0;
    load_ovf   = 1'b0;
    in_rdy     = ap_rst_n && (state_reg == IDLE);
    out_vld    = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (in_vld) begin
          if (ovf_cond) begin
            state_next = DONE;
            load_ovf   = 1'b1;
          end else begin
            state_next = CALC;
            step_en    = 1'b1;
            cnt_next   = 4'd1;
          end
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next = DONE;
          load_res   = 1'b1;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      div_reg  <= '0;
      prem_reg <= '0;
      quo_reg  <= '0;
    end else if (step_en) begin
      if (state_reg == IDLE) begin
        div_reg <= din1;
      end
      prem_reg <= step_prem;
      quo_reg  <= step_quo;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dout_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (load_ovf) begin
      dout_reg <= '1;
      ovf_reg  <= 1'b1;
    end else if (load_res) begin
      dout_reg <= step_quo;
      ovf_reg  <= 1'b0;
    end
  end

  assign dout = dout_reg;
  assign ovf  = ovf_reg;

`ifdef SP_DIV_REM_OUT_EN
  logic [13:0] rem_out_reg;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rem_out_reg <= '0;
    end else if (load_ovf) begin
      rem_out_reg <= '0;
    end else if (load_res) begin
      rem_out_reg <= step_prem;
    end
  end

  assign rem = rem_out_reg;
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_sp_div_udiv_26ns_14ns_12_seq.sv
// Self-checking bench for sp_div_udiv_26ns_14ns_12_seq: directed cases plus a randomized regression
// against an arithmetic reference model. Honours SP_DIV_REM_OUT_EN the same way as the design.
module tb_sp_div_udiv_26ns_14ns_12_seq;

`ifdef SP_DIV_REM_OUT_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [25:0] din0     = '0;
  logic [13:0] din1     = '0;
  logic        in_vld   = 1'b0;
  logic        out_rdy  = 1'b0;
  logic        in_rdy;
  logic [11:0] dout;
  logic [13:0] rem;
  logic        ovf;
  logic        out_vld;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_rdy  = 1'b0;

  always #5 ap_clk = ~ap_clk;

  sp_div_udiv_26ns_14ns_12_seq dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .din0    (din0),
    .din1    (din1),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .dout    (dout),
    .rem     (rem),
    .ovf     (ovf),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: an operation is a latency countdown followed by a held result.
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  logic [11:0] m_q     = '0;
  logic [13:0] m_r     = '0;
  logic        m_o     = 1'b0;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (out_rdy) m_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (in_vld) begin
      if (int'(din0) / 4096 >= int'(din1)) begin
        m_q     <= 12'hFFF;
        m_r     <= '0;
        m_o     <= 1'b1;
        m_valid <= 1'b1;
      end else begin
        m_q    <= 12'(int'(din0) / int'(din1));
        m_r    <= REM_EN ? 14'(int'(din0) % int'(din1)) : 14'd0;
        m_o    <= 1'b0;
        m_busy <= 1'b1;
        m_left <= 11;
      end
    end
  end

  always @(negedge ap_clk) begin
    check("in_rdy", in_rdy, ap_rst_n && !m_busy && !m_valid);
    check("out_vld", out_vld, m_valid);
    if (m_valid) begin
      check("dout", dout, m_q);
      check("rem", rem, m_r);
      check("ovf", ovf, m_o);
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_op(input logic [25:0] a, input logic [13:0] b);
    int g;
    g = 0;
    while (!in_rdy && g < 64) begin
      tick();
      g++;
    end
    if (!in_rdy) timeout("start_in_rdy");
    din0   = a;
    din1   = b;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    din0   = 26'($urandom);
    din1   = 14'($urandom);
  endtask

  task automatic wait_result(output int lat, output logic [11:0] q, output logic [13:0] r,
                             output logic o);
    lat = 1;
    while (!out_vld && lat < 40) begin
      if (rnd_rdy) out_rdy = 1'($urandom);
      tick();
      lat++;
    end
    if (!out_vld) timeout("wait_out_vld");
    q = dout;
    r = rem;
    o = ovf;
  endtask

  task automatic finish_op();
    int g;
    bit hs;
    g = 0;
    do begin
      out_rdy = rnd_rdy ? 1'($urandom) : 1'b1;
      hs = out_rdy && out_vld;
      tick();
      g++;
    end while (!hs && g < 64);
    if (!hs) timeout("handshake");
    if (!rnd_rdy) out_rdy = 1'b0;
  endtask

  task automatic directed(input string name, input logic [25:0] a, input logic [13:0] b,
                          input logic [11:0] eq, input logic [13:0] er, input logic eo,
                          input int elat);
    int lat;
    logic [11:0] q;
    logic [13:0] r;
    logic o;
    start_op(a, b);
    wait_result(lat, q, r, o);
    check({name, "_dout"}, q, eq);
    check({name, "_rem"}, r, er);
    check({name, "_ovf"}, o, eo);
    check({name, "_latency"}, lat, elat);
    $display("op %s: din0=%0d din1=%0d dout=%0d rem=%0d ovf=%0d latency=%0d", name, a, b, q, r, o, lat);
    finish_op();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [11:0] q;
    logic [13:0] r;
    logic o;
    logic [25:0] a;
    logic [13:0] b;
    int unsigned lim;

    // Reset state
    ap_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_dout", dout, 0);
    check("rst_rem", rem, 0);
    check("rst_ovf", ovf, 0);
    ap_rst_n = 1'b1;
    #1;
    check("release_in_rdy", in_rdy, 1);
    tick();

    directed("max", 26'h3FFB001, 14'h3FFF, 12'hFFF, 14'd0, 1'b0, 12);
    directed("d1000_7", 26'd1000, 14'd7, 12'd142, REM_EN ? 14'd6 : 14'd0, 1'b0, 12);
    directed("divzero", 26'd123, 14'd0, 12'hFFF, 14'd0, 1'b1, 1);
    directed("ovf20480", 26'd20480, 14'd5, 12'hFFF, 14'd0, 1'b1, 1);
    directed("d4095_1", 26'd4095, 14'd1, 12'hFFF, 14'd0, 1'b0, 12);
    directed("d4096_1", 26'd4096, 14'd1, 12'hFFF, 14'd0, 1'b1, 1);

    // Result held while downstream stalls
    out_rdy = 1'b0;
    start_op(26'd100, 14'd9);
    wait_result(lat, q, r, o);
    check("hold_dout", q, 11);
    check("hold_rem", r, REM_EN ? 1 : 0);
    check("hold_latency", lat, 12);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_out_vld", out_vld, 1);
      check("hold_dout_stable", dout, 11);
      check("hold_rem_stable", rem, REM_EN ? 1 : 0);
      check("hold_in_rdy", in_rdy, 0);
    end
    $display("op hold: din0=100 din1=9 dout=%0d rem=%0d held 20 cycles", dout, rem);
    out_rdy = 1'b1;
    tick();
    check("hold_release_out_vld", out_vld, 0);
    check("hold_release_in_rdy", in_rdy, 1);
    out_rdy = 1'b0;

    // Reset in the middle of a calculation aborts it
    start_op(26'd1000, 14'd7);
    repeat (4) tick();
    ap_rst_n = 1'b0;
    tick();
    check("abort_out_vld", out_vld, 0);
    check("abort_in_rdy", in_rdy, 0);
    check("abort_dout", dout, 0);
    check("abort_rem", rem, 0);
    check("abort_ovf", ovf, 0);
    ap_rst_n = 1'b1;
    out_rdy  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("abort_no_vld", out_vld, 0);
    end
    out_rdy = 1'b0;
    $display("op abort: reset at step 5, no result emitted");
    directed("d50_5", 26'd50, 14'd5, 12'd10, 14'd0, 1'b0, 12);

    // Randomized regression
    rnd_rdy = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      b = 14'($urandom_range(1, 16383));
      if ($urandom_range(0, 9) == 0) begin
        a = 26'($urandom);
      end else begin
        lim = int'(b) * 4096;
        a = 26'($urandom % lim);
      end
      repeat ($urandom_range(0, 2)) tick();
      start_op(a, b);
      wait_result(lat, q, r, o);
      if (int'(a) / 4096 >= int'(b)) begin
        check("rnd_ovf_flag", o, 1);
        check("rnd_ovf_latency", lat, 1);
      end else begin
        check("rnd_ovf_flag", o, 0);
        check("rnd_latency", lat, 12);
        if (REM_EN) begin
          check("rnd_identity", longint'(q) * longint'(b) + longint'(r), longint'(a));
          check("rnd_rem_lt_div", longint'(r < b), 1);
        end else begin
          check("rnd_quot", q, int'(a) / int'(b));
          check("rnd_rem_zero", r, 0);
        end
      end
      $display("rnd %0d: din0=%0d din1=%0d dout=%0d rem=%0d ovf=%0d latency=%0d", i, a, b, q, r, o, lat);
      finish_op();
    end
    rnd_rdy = 1'b0;
    out_rdy = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
